// File: rtl/dcache_refill_ctrl.sv
// dcache_refill_ctrl: miss handler for the direct-mapped, 8-word-line data cache.
// On a miss it writes back a dirty victim (optional), burst-reads the new line,
// then strobes `refresh_o` for one cycle so the data/tag arrays take the fill.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   miss_i, miss_addr_i       miss request (sampled in IDLE only) and its address
//   victim_dirty_i/_tag_i     victim line state, sampled with the miss
//   stall_o                   pipeline stall (combinational from miss_i in IDLE)
//   write_back_o              one-cycle victim line read; cacheline_old_i valid next cycle
//   refresh_o, refill_tag_o,  one-cycle fill strobe with the new tag and line
//   cacheline_new_o
//   rd_*                      read burst: req/addr held until addr_ok, beats on rd_valid_i
//   wr_*                      write burst: req/addr held until addr_ok, beats on valid&ready,
//                             wr_done_i closes the burst
module dcache_refill_ctrl #(
  parameter int LINE_W = 256,
  parameter int TAG_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_i,
  input  logic [31:0]       miss_addr_i,
  input  logic              victim_dirty_i,
  input  logic [TAG_W-1:0]  victim_tag_i,
  output logic              stall_o,
  output logic              write_back_o,
  input  logic [LINE_W-1:0] cacheline_old_i,
  output logic              refresh_o,
  output logic [TAG_W-1:0]  refill_tag_o,
  output logic [LINE_W-1:0] cacheline_new_o,
  output logic              rd_req_o,
  output logic [31:0]       rd_addr_o,
  input  logic              rd_addr_ok_i,
  input  logic              rd_valid_i,
  input  logic [31:0]       rd_data_i,
  input  logic              rd_last_i,
  output logic              wr_req_o,
  output logic [31:0]       wr_addr_o,
  input  logic              wr_addr_ok_i,
  output logic [31:0]       wr_data_o,
  output logic              wr_valid_o,
  input  logic              wr_ready_i,
  output logic              wr_last_o,
  input  logic              wr_done_i
);

  localparam int WORDS = LINE_W / 32;
  localparam int CNT_W = $clog2(WORDS);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int IDX_W = 32 - TAG_W - OFF_W;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WORDS - 1);
  localparam logic [31:0]      OFF_MSK = 32'(LINE_W / 8 - 1);

  typedef enum logic [3:0] {
    IDLE, WB_RD, WB_LAT, WB_ADDR, WB_DATA, WB_RESP, RD_ADDR, RD_DATA, REFILL, DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            addr_q;
  logic [TAG_W-1:0]       vtag_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [WORDS-1:0][31:0] vbuf_q;  // victim line captured in WB_LAT
  logic [WORDS-1:0][31:0] fbuf_q;  // fill line; words not written keep old contents

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state. The dirty decision is taken in the miss cycle itself, so the
  // victim_dirty value never needs to outlive that cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (miss_i) state_d = victim_dirty_i ? WB_RD : RD_ADDR;
      WB_RD:   state_d = WB_LAT;
      WB_LAT:  state_d = WB_ADDR;
      WB_ADDR: if (wr_addr_ok_i) state_d = WB_DATA;
      WB_DATA: if (wr_ready_i && cnt_q == LAST) state_d = WB_RESP;
      WB_RESP: if (wr_done_i) state_d = RD_ADDR;
      RD_ADDR: if (rd_addr_ok_i) state_d = RD_DATA;
      RD_DATA: if (rd_valid_i && rd_last_i) state_d = REFILL;  // early last still refills
      REFILL:  state_d = DONE;
      DONE:    state_d = IDLE;  // a miss here is ignored; pipeline replays and hits
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state (stall additionally from miss_i in IDLE)
  always_comb begin
    stall_o      = 1'b1;
    write_back_o = 1'b0;
    refresh_o    = 1'b0;
    rd_req_o     = 1'b0;
    wr_req_o     = 1'b0;
    wr_valid_o   = 1'b0;
    wr_last_o    = 1'b0;
    unique case (state_q)
      IDLE:    stall_o = miss_i;
      WB_RD:   write_back_o = 1'b1;
      WB_ADDR: wr_req_o = 1'b1;
      WB_DATA: begin
        wr_valid_o = 1'b1;
        wr_last_o  = (cnt_q == LAST);
      end
      RD_ADDR: rd_req_o = 1'b1;
      REFILL:  refresh_o = 1'b1;
      DONE:    stall_o = 1'b0;
      default: ;
    endcase
  end

  // Datapath: latched miss, beat counter, victim and fill buffers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      vtag_q <= '0;
      cnt_q  <= '0;
      vbuf_q <= '0;
      fbuf_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (miss_i) begin
          addr_q <= miss_addr_i;
          vtag_q <= victim_tag_i;
        end
        WB_LAT:  vbuf_q <= cacheline_old_i;
        WB_ADDR: if (wr_addr_ok_i) cnt_q <= '0;
        WB_DATA: if (wr_ready_i) cnt_q <= cnt_q + 1'b1;
        RD_ADDR: if (rd_addr_ok_i) cnt_q <= '0;
        RD_DATA: if (rd_valid_i) begin
          fbuf_q[cnt_q] <= rd_data_i;
          cnt_q         <= cnt_q + 1'b1;  // wraps after the 8th beat
        end
        default: ;
      endcase
    end
  end

  // wr_data only moves when cnt_q does, i.e. after a handshake
  assign wr_data_o       = vbuf_q[cnt_q];
  assign rd_addr_o       = addr_q & ~OFF_MSK;
  assign wr_addr_o       = {vtag_q, addr_q[OFF_W +: IDX_W], {OFF_W{1'b0}}};
  assign refill_tag_o    = addr_q[31 -: TAG_W];
  assign cacheline_new_o = fbuf_q;

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
module tb_dcache_refill_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic miss_i, victim_dirty_i, stall_o, write_back_o, refresh_o;
  logic [31:0] miss_addr_i, rd_addr_o, rd_data_i, wr_addr_o, wr_data_o;
  logic [19:0] victim_tag_i, refill_tag_o;
  logic [255:0] cacheline_old_i, cacheline_new_o;
  logic rd_req_o, rd_addr_ok_i, rd_valid_i, rd_last_i;
  logic wr_req_o, wr_addr_ok_i, wr_valid_o, wr_ready_i, wr_last_o, wr_done_i;

  always #5 clk = ~clk;

  dcache_refill_ctrl dut (
    .clk(clk), .rst(rst), .miss_i(miss_i), .miss_addr_i(miss_addr_i),
    .victim_dirty_i(victim_dirty_i), .victim_tag_i(victim_tag_i), .stall_o(stall_o),
    .write_back_o(write_back_o), .cacheline_old_i(cacheline_old_i), .refresh_o(refresh_o),
    .refill_tag_o(refill_tag_o), .cacheline_new_o(cacheline_new_o), .rd_req_o(rd_req_o),
    .rd_addr_o(rd_addr_o), .rd_addr_ok_i(rd_addr_ok_i), .rd_valid_i(rd_valid_i),
    .rd_data_i(rd_data_i), .rd_last_i(rd_last_i), .wr_req_o(wr_req_o), .wr_addr_o(wr_addr_o),
    .wr_addr_ok_i(wr_addr_ok_i), .wr_data_o(wr_data_o), .wr_valid_o(wr_valid_o),
    .wr_ready_i(wr_ready_i), .wr_last_o(wr_last_o), .wr_done_i(wr_done_i)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the line the cache would hold after each fill
  logic [31:0] model_line [8];
  logic [31:0] beats [8];   // read data the bus returns
  logic [31:0] oldw  [8];   // victim line contents

  // Observations from one miss
  int r_stall, r_refresh_n, r_refresh_cyc, r_wb_n, r_wb_cyc, r_rdreq_n, r_rdreq_first;
  int r_wrreq_n, r_both, r_addr_bad, r_early_rd, r_hold_bad, r_last_rd_cyc, r_done;
  logic r_post_stall, r_post_rdreq;
  logic [255:0] r_line;
  logic [19:0]  r_tag;
  logic [31:0]  r_wdata [$];
  logic         r_wlast [$];

  function automatic logic [255:0] pack8(input logic [31:0] w [8]);
    logic [255:0] p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = w[i];
    return p;
  endfunction

  task automatic model_refill(input int n, output logic [255:0] exp);
    for (int i = 0; i < n; i++) model_line[i] = beats[i];
    exp = pack8(model_line);
  endtask

  task automatic idle_inputs;
    miss_i = 0; miss_addr_i = 0; victim_dirty_i = 0; victim_tag_i = 0;
    cacheline_old_i = '0; rd_addr_ok_i = 0; rd_valid_i = 0; rd_data_i = 0;
    rd_last_i = 0; wr_addr_ok_i = 0; wr_ready_i = 0; wr_done_i = 0;
  endtask

  // Plays one miss as a bus/cache environment. Entered and left just after a posedge.
  task automatic run_miss(input logic [31:0] addr, input logic dirty, input logic [19:0] vtag,
                          input int nbeats, input int ok_delay, input bit wr_toggle,
                          input int gap_pct, input bit hold_miss, input int rst_beat);
    logic [31:0] exp_rd, exp_wr, ndata, pd;
    int nxt, seen, wd_cyc, rst_cyc;
    bit rd_acc, acc_now, nv, nlast, nrst, nwd, nold, pv, pr;
    exp_rd = {addr[31:5], 5'b0};
    exp_wr = {vtag, addr[11:5], 5'b0};
    r_stall = 0; r_refresh_n = 0; r_refresh_cyc = -1; r_wb_n = 0; r_wb_cyc = -1;
    r_rdreq_n = 0; r_rdreq_first = -1; r_wrreq_n = 0; r_both = 0; r_addr_bad = 0;
    r_early_rd = 0; r_hold_bad = 0; r_last_rd_cyc = -1; r_done = 0;
    r_post_stall = 1; r_post_rdreq = 1; r_line = 'x; r_tag = 'x;
    r_wdata.delete(); r_wlast.delete();
    nxt = 0; seen = 0; wd_cyc = -1; rst_cyc = -1; rd_acc = 0; pv = 0; pr = 0; pd = 0;
    miss_i = 1; miss_addr_i = addr; victim_dirty_i = dirty; victim_tag_i = vtag;
    rd_addr_ok_i = (ok_delay == 0); wr_addr_ok_i = 1; wr_ready_i = 1;
    rd_valid_i = 0; rd_last_i = 0; rd_data_i = $urandom; wr_done_i = 0;
    cacheline_old_i = {8{$urandom}};
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (stall_o) r_stall++;
      if (write_back_o) begin r_wb_n++; r_wb_cyc = c; end
      if (write_back_o && refresh_o) r_both++;
      if (rd_req_o) begin
        r_rdreq_n++;
        if (r_rdreq_first < 0) r_rdreq_first = c;
        if (rd_addr_o !== exp_rd) r_addr_bad++;
        if (dirty && !(wd_cyc >= 0 && wd_cyc < c)) r_early_rd++;
      end
      if (wr_req_o) begin
        r_wrreq_n++;
        if (wr_addr_o !== exp_wr) r_addr_bad++;
      end
      if (pv && !pr && wr_valid_o && wr_data_o !== pd) r_hold_bad++;
      pv = wr_valid_o; pr = wr_ready_i; pd = wr_data_o;
      if (wr_valid_o && wr_ready_i) begin r_wdata.push_back(wr_data_o); r_wlast.push_back(wr_last_o); end
      if (refresh_o) begin r_refresh_n++; r_refresh_cyc = c; r_line = cacheline_new_o; r_tag = refill_tag_o; end
      if (rst_cyc >= 0) begin
        if (c == rst_cyc + 1) begin r_post_stall = stall_o; r_post_rdreq = rd_req_o; end
        if (c == rst_cyc + 4) begin r_line = cacheline_new_o; r_done = 1; break; end
      end else if (r_refresh_n > 0 && c > r_refresh_cyc && !stall_o) begin
        r_done = 1; break;
      end
      acc_now = rd_req_o && rd_addr_ok_i;
      if (rd_req_o) seen++;
      nwd  = wr_valid_o && wr_ready_i && wr_last_o;
      nold = write_back_o;
      nv = 0; nlast = 0; nrst = 0; ndata = $urandom;
      if ((rd_acc || acc_now) && rst_cyc < 0 && nxt < nbeats &&
          (gap_pct == 0 || $urandom_range(99) >= gap_pct)) begin
        nv = 1; ndata = beats[nxt]; nlast = (nxt == nbeats - 1); nrst = (nxt == rst_beat);
        if (nlast) r_last_rd_cyc = c + 1;
        nxt++;
      end
      if (acc_now) rd_acc = 1;
      @(posedge clk); #1;
      miss_i = hold_miss; rd_addr_ok_i = (seen >= ok_delay);
      wr_ready_i = wr_toggle ? ~wr_ready_i : 1'b1;
      rd_valid_i = nv; rd_data_i = ndata; rd_last_i = nlast; rst = nrst; wr_done_i = nwd;
      if (nwd) wd_cyc = c + 1;
      cacheline_old_i = nold ? pack8(oldw) : {8{$urandom}};
      if (nrst) rst_cyc = c + 1;
    end
    if (r_done == 0) begin
      total++; bad++;
      $display("FAIL run_miss_timeout addr=%h refreshes=%0d", addr, r_refresh_n);
    end
    @(posedge clk); #1;
    miss_i = hold_miss; rd_valid_i = 0; rd_last_i = 0; wr_done_i = 0; rst = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 8; i++) model_line[i] = 0;
    @(negedge clk);
    total++;
    if ({stall_o, write_back_o, refresh_o, rd_req_o, wr_req_o, wr_valid_o, wr_last_o} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0000000",
        {stall_o, write_back_o, refresh_o, rd_req_o, wr_req_o, wr_valid_o, wr_last_o});
    end
    total++;
    if ({rd_addr_o, wr_addr_o, wr_data_o, refill_tag_o} !== 116'b0) begin
      bad++; $display("FAIL reset_bus got rd=%h wr=%h wd=%h tag=%h want 0",
        rd_addr_o, wr_addr_o, wr_data_o, refill_tag_o);
    end
    total++;
    if (cacheline_new_o !== 256'b0) begin
      bad++; $display("FAIL reset_line got=%h want=0", cacheline_new_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clean_miss;
    logic [255:0] exp;
    for (int i = 0; i < 8; i++) beats[i] = 32'h1000 + i;
    run_miss(32'h0000_1A40, 1'b0, 20'($urandom), 8, 0, 0, 0, 0, -1);
    model_refill(8, exp);
    total++;
    if (r_rdreq_first != 1 || r_rdreq_n != 1 || r_addr_bad != 0) begin
      bad++; $display("FAIL clean_rd_req first=%0d n=%0d addr_bad=%0d want 1/1/0",
        r_rdreq_first, r_rdreq_n, r_addr_bad);
    end
    total++;
    if (r_refresh_cyc != 10 || r_refresh_n != 1) begin
      bad++; $display("FAIL clean_refresh cyc=%0d n=%0d want 10/1", r_refresh_cyc, r_refresh_n);
    end
    total++;
    if (r_line !== exp) begin bad++; $display("FAIL clean_line got=%h want=%h", r_line, exp); end
    total++;
    if (r_tag !== 20'h00001) begin bad++; $display("FAIL clean_tag got=%h want=00001", r_tag); end
    total++;
    if (r_stall != 11) begin bad++; $display("FAIL clean_stall got=%0d want=11", r_stall); end
    total++;
    if (r_wb_n != 0 || r_wrreq_n != 0 || r_wdata.size() != 0) begin
      bad++; $display("FAIL clean_no_wb wb=%0d wrreq=%0d beats=%0d want 0", r_wb_n, r_wrreq_n, r_wdata.size());
    end
  endtask

  task automatic test_dirty_miss;
    logic [255:0] exp;
    int nmis;
    for (int i = 0; i < 8; i++) begin oldw[i] = 32'hD0 + i; beats[i] = $urandom; end
    run_miss({20'h12345, 7'h52, 5'h0}, 1'b1, 20'h00ABC, 8, 0, 0, 0, 0, -1);
    model_refill(8, exp);
    total++;
    if (r_wb_n != 1 || r_wb_cyc != 1 || r_both != 0) begin
      bad++; $display("FAIL dirty_wb n=%0d cyc=%0d both=%0d want 1/1/0", r_wb_n, r_wb_cyc, r_both);
    end
    total++;
    if (r_wrreq_n != 1 || r_addr_bad != 0) begin
      bad++; $display("FAIL dirty_wr_addr n=%0d addr_bad=%0d want 1/0 (0x00ABCA40)", r_wrreq_n, r_addr_bad);
    end
    nmis = 0;
    for (int i = 0; i < r_wdata.size() && i < 8; i++)
      if (r_wdata[i] !== oldw[i] || r_wlast[i] !== (i == 7)) nmis++;
    total++;
    if (r_wdata.size() != 8 || nmis != 0) begin
      bad++; $display("FAIL dirty_beats count=%0d bad=%0d want 8/0", r_wdata.size(), nmis);
    end
    total++;
    if (r_early_rd != 0 || r_rdreq_first != 13) begin
      bad++; $display("FAIL dirty_rd_order early=%0d first=%0d want 0/13", r_early_rd, r_rdreq_first);
    end
    total++;
    if (r_refresh_cyc != 22 || r_stall != 23) begin
      bad++; $display("FAIL dirty_timing refresh=%0d stall=%0d want 22/23", r_refresh_cyc, r_stall);
    end
    total++;
    if (r_line !== exp) begin bad++; $display("FAIL dirty_line got=%h want=%h", r_line, exp); end
  endtask

  task automatic test_back_pressure;
    logic [255:0] exp;
    int nmis;
    for (int i = 0; i < 8; i++) begin oldw[i] = $urandom; beats[i] = $urandom; end
    run_miss($urandom, 1'b1, 20'($urandom), 8, 5, 1, 30, 0, -1);
    model_refill(8, exp);
    nmis = 0;
    for (int i = 0; i < r_wdata.size() && i < 8; i++)
      if (r_wdata[i] !== oldw[i] || r_wlast[i] !== (i == 7)) nmis++;
    total++;
    if (r_wdata.size() != 8 || nmis != 0 || r_hold_bad != 0) begin
      bad++; $display("FAIL bp_wr_beats count=%0d bad=%0d hold_bad=%0d want 8/0/0",
        r_wdata.size(), nmis, r_hold_bad);
    end
    total++;
    if (r_rdreq_n != 6 || r_addr_bad != 0 || r_early_rd != 0) begin
      bad++; $display("FAIL bp_rd_req n=%0d addr_bad=%0d early=%0d want 6/0/0",
        r_rdreq_n, r_addr_bad, r_early_rd);
    end
    total++;
    if (r_line !== exp) begin bad++; $display("FAIL bp_line got=%h want=%h", r_line, exp); end
    total++;
    if (r_refresh_cyc != r_last_rd_cyc + 1 || r_stall != r_refresh_cyc + 1) begin
      bad++; $display("FAIL bp_timing refresh=%0d last=%0d stall=%0d", r_refresh_cyc, r_last_rd_cyc, r_stall);
    end
  endtask

  task automatic test_back_to_back;
    logic [255:0] exp;
    for (int i = 0; i < 8; i++) beats[i] = $urandom;
    run_miss(32'h0040_0100, 1'b0, 20'h0, 8, 0, 0, 0, 1, -1);
    model_refill(8, exp);
    total++;
    if (r_line !== exp) begin bad++; $display("FAIL b2b_first_line got=%h want=%h", r_line, exp); end
    for (int i = 0; i < 8; i++) beats[i] = $urandom;
    run_miss(32'h0080_0200, 1'b0, 20'h0, 8, 0, 0, 0, 0, -1);
    model_refill(8, exp);
    total++;
    if (r_rdreq_first != 1 || r_addr_bad != 0 || r_stall != 11) begin
      bad++; $display("FAIL b2b_second first=%0d addr_bad=%0d stall=%0d want 1/0/11",
        r_rdreq_first, r_addr_bad, r_stall);
    end
    total++;
    if (r_line !== exp) begin bad++; $display("FAIL b2b_second_line got=%h want=%h", r_line, exp); end
  endtask

  task automatic test_short_burst;
    logic [255:0] exp;
    for (int i = 0; i < 8; i++) beats[i] = $urandom;
    run_miss($urandom, 1'b0, 20'h0, 6, 0, 0, 0, 0, -1);
    model_refill(6, exp);
    total++;
    if (r_line !== exp) begin bad++; $display("FAIL short_line got=%h want=%h", r_line, exp); end
    total++;
    if (r_refresh_n != 1 || r_refresh_cyc != r_last_rd_cyc + 1) begin
      bad++; $display("FAIL short_refresh n=%0d cyc=%0d last=%0d", r_refresh_n, r_refresh_cyc, r_last_rd_cyc);
    end
  endtask

  task automatic test_reset_mid_burst;
    for (int i = 0; i < 8; i++) beats[i] = $urandom;
    run_miss($urandom, 1'b0, 20'h0, 8, 0, 0, 0, 0, 4);
    for (int i = 0; i < 8; i++) model_line[i] = 0;
    total++;
    if (r_post_stall !== 1'b0 || r_post_rdreq !== 1'b0) begin
      bad++; $display("FAIL rst_mid stall=%b rd_req=%b want 0/0", r_post_stall, r_post_rdreq);
    end
    total++;
    if (r_refresh_n != 0) begin bad++; $display("FAIL rst_mid_refresh got=%0d want=0", r_refresh_n); end
    total++;
    if (r_line !== 256'b0) begin bad++; $display("FAIL rst_mid_line got=%h want=0", r_line); end
  endtask

  task automatic test_random;
    logic [255:0] exp;
    logic [31:0] addr;
    logic d;
    int nmis;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 8; i++) begin oldw[i] = $urandom; beats[i] = $urandom; end
      addr = $urandom;
      d = 1'($urandom_range(1));
      run_miss(addr, d, 20'($urandom), 8, $urandom_range(3), 1'($urandom_range(1)),
               $urandom_range(40), 0, -1);
      model_refill(8, exp);
      total++;
      if (r_line !== exp || r_tag !== addr[31:12]) begin
        bad++; $display("FAIL rand_fill[%0d] line=%h tag=%h want line=%h tag=%h", t, r_line, r_tag, exp, addr[31:12]);
      end
      nmis = 0;
      for (int i = 0; i < r_wdata.size() && i < 8; i++)
        if (r_wdata[i] !== oldw[i] || r_wlast[i] !== (i == 7)) nmis++;
      total++;
      if (r_wdata.size() != (d ? 8 : 0) || nmis != 0 || r_addr_bad != 0 || r_early_rd != 0) begin
        bad++; $display("FAIL rand_bus[%0d] beats=%0d bad=%0d addr_bad=%0d early=%0d dirty=%b",
          t, r_wdata.size(), nmis, r_addr_bad, r_early_rd, d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_back_pressure();
    test_back_to_back();
    test_short_burst();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
